// File: rtl/bellman_relax_engine.sv
// bellman_relax_engine
//   Bellman-Ford relaxation engine over a NODES x NODES adjacency matrix of
//   signed log-rate weights. Distances and predecessors live in an external
//   dual-port vertex memory with a one-cycle registered read. A run stops early
//   when a pass makes no relaxation. If all NODES-1 passes still relax, a
//   read-only check pass looks for a further relaxing edge, which indicates a
//   negative cycle (an arbitrage opportunity).
//
// Ports
//   clk, bellman_reset_n          clock, synchronous active-low reset
//   start, src                    start pulse (ignored while busy), source vertex
//   adjmat_q                      {edge present, signed weight}, registered read
//   adjmat_row/col_addr           edge (i,j) address
//   vertmat_q_a/b                 {pred, dist} read data, one cycle after address
//   vertmat_addr_a/b              port A = vertex i (source), port B = vertex j
//   vertmat_data_a/b, we_a/b      write data/enables (A in INIT, B in RELAX)
//   busy, done                    run in progress / run finished (held)
//   neg_cycle, cycle_vertex       negative cycle found, and the vertex j of the
//                                 first edge that relaxed in the check pass
//   pass_count                    relaxation passes executed (check excluded)
module bellman_relax_engine #(
  parameter int NODES    = 16,
  parameter int WEIGHT_W = 32,
  parameter int PRED_W   = $clog2(NODES)
) (
  input  logic                       clk,
  input  logic                       bellman_reset_n,
  input  logic                       start,
  input  logic [PRED_W-1:0]          src,
  input  logic [WEIGHT_W:0]          adjmat_q,
  input  logic [PRED_W+WEIGHT_W-1:0] vertmat_q_a,
  input  logic [PRED_W+WEIGHT_W-1:0] vertmat_q_b,
  output logic [PRED_W-1:0]          adjmat_row_addr,
  output logic [PRED_W-1:0]          adjmat_col_addr,
  output logic [PRED_W-1:0]          vertmat_addr_a,
  output logic [PRED_W-1:0]          vertmat_addr_b,
  output logic [PRED_W+WEIGHT_W-1:0] vertmat_data_a,
  output logic [PRED_W+WEIGHT_W-1:0] vertmat_data_b,
  output logic                       vertmat_we_a,
  output logic                       vertmat_we_b,
  output logic                       busy,
  output logic                       done,
  output logic                       neg_cycle,
  output logic [PRED_W-1:0]          cycle_vertex,
  output logic [PRED_W:0]            pass_count
);

  localparam logic signed [WEIGHT_W-1:0] INF = {1'b0, {(WEIGHT_W-1){1'b1}}};
  // Saturation bounds for the (WEIGHT_W+1)-bit sum: [-2^(W-1), INF-1].
  // The upper bound stays below INF so a reached vertex never looks unreached.
  localparam logic signed [WEIGHT_W:0] SUM_MAX = {2'b00, {(WEIGHT_W-2){1'b1}}, 1'b0};
  localparam logic signed [WEIGHT_W:0] SUM_MIN = {2'b11, {(WEIGHT_W-1){1'b0}}};
  localparam logic [PRED_W-1:0] LAST    = PRED_W'(NODES-1);
  localparam logic [PRED_W-1:0] IDX_ONE = PRED_W'(1);
  localparam logic [PRED_W:0]   PC_ONE  = (PRED_W+1)'(1);
  localparam logic [PRED_W:0]   PC_LAST = (PRED_W+1)'(NODES-1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_READ, S_RELAX, S_PASS_END, S_CHECK_READ, S_CHECK, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [PRED_W-1:0] src_r, k, i, j;
  logic              changed;

  logic signed [WEIGHT_W-1:0] svw, dvw, ew, sum, init_dist;
  logic                       relax_hit, last_edge;
  logic                       unused_pred;

  function automatic logic signed [WEIGHT_W-1:0] sat_add(
    input logic signed [WEIGHT_W-1:0] a,
    input logic signed [WEIGHT_W-1:0] b
  );
    logic signed [WEIGHT_W:0] s;
    s = $signed({a[WEIGHT_W-1], a}) + $signed({b[WEIGHT_W-1], b});
    if (s > SUM_MAX)      s = SUM_MAX;
    else if (s < SUM_MIN) s = SUM_MIN;
    return s[WEIGHT_W-1:0];
  endfunction

  // Predecessor fields are written here but never read back.
  assign unused_pred = ^{vertmat_q_a[PRED_W+WEIGHT_W-1:WEIGHT_W],
                         vertmat_q_b[PRED_W+WEIGHT_W-1:WEIGHT_W]};

  assign svw       = vertmat_q_a[WEIGHT_W-1:0];
  assign dvw       = vertmat_q_b[WEIGHT_W-1:0];
  assign ew        = adjmat_q[WEIGHT_W-1:0];
  assign sum       = sat_add(svw, ew);
  assign relax_hit = adjmat_q[WEIGHT_W] && (svw != INF) && (i != j) && (sum < dvw);
  assign last_edge = (i == LAST) && (j == LAST);
  assign init_dist = (k == src_r) ? '0 : INF;

  always_ff @(posedge clk) begin
    if (!bellman_reset_n) state <= S_IDLE;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    vertmat_we_a    = 1'b0;
    vertmat_we_b    = 1'b0;
    vertmat_addr_a  = '0;
    vertmat_addr_b  = '0;
    adjmat_row_addr = '0;
    adjmat_col_addr = '0;
    vertmat_data_a  = '0;
    vertmat_data_b  = '0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nxt = S_INIT;
      end
      S_INIT: begin
        vertmat_we_a   = 1'b1;
        vertmat_addr_a = k;
        vertmat_data_a = {k, init_dist};
        if (k == LAST) state_nxt = S_READ;
      end
      S_READ, S_CHECK_READ: begin
        adjmat_row_addr = i;
        adjmat_col_addr = j;
        vertmat_addr_a  = i;
        vertmat_addr_b  = j;
        state_nxt       = (state == S_READ) ? S_RELAX : S_CHECK;
      end
      S_RELAX: begin
        adjmat_row_addr = i;
        adjmat_col_addr = j;
        vertmat_addr_a  = i;
        vertmat_addr_b  = j;
        if (relax_hit) begin
          vertmat_we_b   = 1'b1;
          vertmat_data_b = {i, sum};
        end
        state_nxt = last_edge ? S_PASS_END : S_READ;
      end
      S_PASS_END: begin
        if (!changed)                          state_nxt = S_DONE;
        else if (pass_count + PC_ONE == PC_LAST) state_nxt = S_CHECK_READ;
        else                                   state_nxt = S_READ;
      end
      S_CHECK: begin
        adjmat_row_addr = i;
        adjmat_col_addr = j;
        vertmat_addr_a  = i;
        vertmat_addr_b  = j;
        if (relax_hit || last_edge) state_nxt = S_DONE;
        else                        state_nxt = S_CHECK_READ;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Reset must silence the write ports within the cycle it is asserted.
    if (!bellman_reset_n) begin
      vertmat_we_a = 1'b0;
      vertmat_we_b = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!bellman_reset_n) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      neg_cycle    <= 1'b0;
      cycle_vertex <= '0;
      pass_count   <= '0;
      src_r        <= '0;
      k            <= '0;
      i            <= '0;
      j            <= '0;
      changed      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            src_r      <= src;
            k          <= '0;
            i          <= '0;
            j          <= '0;
            pass_count <= '0;
            changed    <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            neg_cycle  <= 1'b0;
          end
        end
        S_INIT: k <= k + IDX_ONE;
        S_RELAX, S_CHECK: begin
          if (state == S_RELAX && relax_hit) changed <= 1'b1;
          if (state == S_CHECK && (relax_hit || last_edge)) begin
            neg_cycle <= relax_hit;
            if (relax_hit) cycle_vertex <= j;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
          // Row-major scan; explicit wrap keeps non-power-of-two NODES correct.
          if (j == LAST) begin
            j <= '0;
            i <= (i == LAST) ? '0 : i + IDX_ONE;
          end else begin
            j <= j + IDX_ONE;
          end
        end
        S_PASS_END: begin
          pass_count <= pass_count + PC_ONE;
          if (!changed) begin
            neg_cycle <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            changed <= 1'b0;
            i       <= '0;
            j       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bellman_relax_engine.sv
// Bench for bellman_relax_engine with NODES=4, WEIGHT_W=8 (INF=127).
// Holds behavioural adjacency/vertex memories, a plain Bellman-Ford model
// with in-place row-major updates and saturation, and directed scenarios.
module tb_bellman_relax_engine;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int PW  = 2;
  localparam int INF = 127;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              bellman_reset_n;
  logic              start;
  logic [PW-1:0]     src;
  logic [W:0]        adjmat_q;
  logic [PW+W-1:0]   vertmat_q_a, vertmat_q_b;
  logic [PW-1:0]     adjmat_row_addr, adjmat_col_addr, vertmat_addr_a, vertmat_addr_b;
  logic [PW+W-1:0]   vertmat_data_a, vertmat_data_b;
  logic              vertmat_we_a, vertmat_we_b;
  logic              busy, done, neg_cycle;
  logic [PW-1:0]     cycle_vertex;
  logic [PW:0]       pass_count;

  bellman_relax_engine #(.NODES(N), .WEIGHT_W(W), .PRED_W(PW)) dut (
    .clk(clk), .bellman_reset_n(bellman_reset_n), .start(start), .src(src),
    .adjmat_q(adjmat_q), .vertmat_q_a(vertmat_q_a), .vertmat_q_b(vertmat_q_b),
    .adjmat_row_addr(adjmat_row_addr), .adjmat_col_addr(adjmat_col_addr),
    .vertmat_addr_a(vertmat_addr_a), .vertmat_addr_b(vertmat_addr_b),
    .vertmat_data_a(vertmat_data_a), .vertmat_data_b(vertmat_data_b),
    .vertmat_we_a(vertmat_we_a), .vertmat_we_b(vertmat_we_b),
    .busy(busy), .done(done), .neg_cycle(neg_cycle),
    .cycle_vertex(cycle_vertex), .pass_count(pass_count)
  );

  // Registered-read memories.
  logic [W:0]      adj  [N][N];
  logic [PW+W-1:0] vmem [N];
  always @(posedge clk) begin
    if (vertmat_we_a) vmem[vertmat_addr_a] <= vertmat_data_a;
    if (vertmat_we_b) vmem[vertmat_addr_b] <= vertmat_data_b;
    vertmat_q_a <= vmem[vertmat_addr_a];
    vertmat_q_b <= vmem[vertmat_addr_b];
    adjmat_q    <= adj[adjmat_row_addr][adjmat_col_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Graph and model state.
  bit ep [N][N];
  int ew [N][N];
  int md [N];
  int mp [N];
  int mP, mneg, mcv, mlat;

  task automatic clear_edges();
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++) begin
        ep[a][b] = 1'b0;
        ew[a][b] = 0;
      end
  endtask

  task automatic add_edge(input int a, input int b, input int w);
    ep[a][b] = 1'b1;
    ew[a][b] = w;
  endtask

  task automatic load_adj();
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++)
        adj[a][b] = {ep[a][b], W'(ew[a][b])};
  endtask

  function automatic bit relaxes(input int a, input int b, output int s);
    s = md[a] + ew[a][b];
    if (s > INF - 1) s = INF - 1;
    if (s < -INF - 1) s = -INF - 1;
    return ep[a][b] && (md[a] != INF) && (a != b) && (s < md[b]);
  endfunction

  task automatic model(input int s);
    int  sum;
    bit  changed;
    bit  found;
    for (int v = 0; v < N; v++) begin
      md[v] = (v == s) ? 0 : INF;
      mp[v] = v;
    end
    mP = 0; mneg = 0; mcv = 0; changed = 1'b0;
    for (int p = 0; p < N - 1; p++) begin
      changed = 1'b0;
      for (int a = 0; a < N; a++)
        for (int b = 0; b < N; b++)
          if (relaxes(a, b, sum)) begin
            md[b] = sum;
            mp[b] = a;
            changed = 1'b1;
          end
      mP++;
      if (!changed) break;
    end
    mlat = 1 + N + mP * (2 * N * N + 1);
    if (changed) begin
      found = 1'b0;
      for (int idx = 0; idx < N * N; idx++)
        if (!found && relaxes(idx / N, idx % N, sum)) begin
          found = 1'b1;
          mneg  = 1;
          mcv   = idx % N;
          mlat += 2 * (idx + 1);
        end
      if (!found) mlat += 2 * N * N;
    end
  endtask

  // Start a run, check handshake/write-port behaviour every cycle against the
  // model latency, then check the final vertex memory and result outputs.
  task automatic run(input string tag, input int s, input bit inject);
    int cyc;
    model(s);
    load_adj();
    @(negedge clk);
    src = PW'(s); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc <= mlat) begin
      check({tag, ".busy"}, busy, (cyc < mlat) ? 1 : 0);
      check({tag, ".done"}, done, (cyc >= mlat) ? 1 : 0);
      check({tag, ".we_a"}, vertmat_we_a, (cyc <= N) ? 1 : 0);
      check({tag, ".we_excl"}, vertmat_we_a & vertmat_we_b, 0);
      if (inject && cyc == 10) begin
        start = 1'b1;
        src   = PW'(N - 1 - s);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    for (int v = 0; v < N; v++) begin
      check({tag, ".dist"}, int'($signed(vmem[v][W-1:0])), md[v]);
      check({tag, ".pred"}, int'(vmem[v][PW+W-1:W]), mp[v]);
    end
    check({tag, ".pass_count"}, int'(pass_count), mP);
    check({tag, ".neg_cycle"}, int'(neg_cycle), mneg);
    if (mneg != 0) check({tag, ".cycle_vertex"}, int'(cycle_vertex), mcv);
  endtask

  initial begin
    bit found;
    bellman_reset_n = 1'b0;
    start = 1'b0;
    src = '0;
    clear_edges();
    load_adj();
    repeat (3) @(negedge clk);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.neg_cycle", neg_cycle, 0);
    check("rst.we", {vertmat_we_a, vertmat_we_b}, 0);
    check("rst.pass_count", int'(pass_count), 0);
    check("rst.cycle_vertex", int'(cycle_vertex), 0);
    check("rst.addr", {adjmat_row_addr, adjmat_col_addr, vertmat_addr_a, vertmat_addr_b}, 0);
    bellman_reset_n = 1'b1;

    // Chain with early exit.
    clear_edges();
    add_edge(0, 1, 5); add_edge(1, 2, -2); add_edge(2, 3, 4);
    run("chain", 0, 1'b0);
    check("chain.model_d3", md[3], 7);
    check("chain.model_p3", mp[3], 2);
    check("chain.model_lat", mlat, 71);
    check("chain.d2_lit", int'($signed(vmem[2][W-1:0])), 3);
    check("chain.pc_lit", int'(pass_count), 2);

    // No edges, src 2: one pass, done at cycle 38.
    clear_edges();
    run("noedge", 2, 1'b0);
    check("noedge.model_lat", mlat, 38);
    check("noedge.d0_lit", int'($signed(vmem[0][W-1:0])), INF);
    check("noedge.d2_lit", int'($signed(vmem[2][W-1:0])), 0);
    check("noedge.pc_lit", int'(pass_count), 1);

    // Negative cycle 0->1->2->0.
    clear_edges();
    add_edge(0, 1, 1); add_edge(1, 2, -3); add_edge(2, 0, 1);
    run("negcyc", 0, 1'b0);
    check("negcyc.model_lat", mlat, 108);
    check("negcyc.neg_lit", int'(neg_cycle), 1);
    check("negcyc.cv_lit", int'(cycle_vertex), 1);
    check("negcyc.pc_lit", int'(pass_count), 3);

    // Saturation at both ends.
    clear_edges();
    add_edge(0, 1, -128); add_edge(1, 2, -100); add_edge(0, 3, 127);
    run("sat", 0, 1'b0);
    check("sat.d1_lit", int'($signed(vmem[1][W-1:0])), -128);
    check("sat.d2_lit", int'($signed(vmem[2][W-1:0])), -128);
    check("sat.d3_lit", int'($signed(vmem[3][W-1:0])), 126);

    // Start pulse while busy with a different src is ignored.
    clear_edges();
    add_edge(0, 1, 5); add_edge(1, 2, -2); add_edge(2, 3, 4);
    run("ignstart", 0, 1'b1);
    check("ignstart.d3_lit", int'($signed(vmem[3][W-1:0])), 7);

    // Reset during a RELAX write.
    model(0);
    load_adj();
    @(negedge clk);
    src = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      if (vertmat_we_b) found = 1'b1;
      else @(negedge clk);
    end
    check("rstmid.we_b_seen", found, 1);
    bellman_reset_n = 1'b0;
    #1;
    check("rstmid.we_b_now", vertmat_we_b, 0);
    @(negedge clk);
    check("rstmid.busy", busy, 0);
    check("rstmid.done", done, 0);
    check("rstmid.we", {vertmat_we_a, vertmat_we_b}, 0);
    bellman_reset_n = 1'b1;
    run("after_rst", 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
